// File: rtl/cpu_memstage_pkg.sv
// cpu_memstage shared types: memory op/size encodings,
// control-bit layout and the alignment rule.
package cpu_memstage_pkg;

  localparam int PCB_WIDTH = 8;
  localparam int PCB_WA = 0;
  localparam int PCB_WM = 1;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'b00,
    MEM_OP_LOAD  = 2'b01,
    MEM_OP_STORE = 2'b10
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10
  } mem_size_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_e;

  function automatic logic is_aligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    if (size == MEM_SIZE_B) return 1'b1;
    if (size == MEM_SIZE_H) return ~lo[0];
    return lo == 2'b00;
  endfunction

endpackage

// File: rtl/cpu_memstage_if.sv
// Wishbone data-bus bundle between the memory stage
// and the data slave.
interface cpu_memstage_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/cpu_memlane.sv
// Big-endian byte-lane steering: lane selects, store
// replication and zero-extended load extraction.
module cpu_memlane
  import cpu_memstage_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [4:0] sh;

  always_comb begin
    sel_o   = 4'hF;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    sh      = '0;
    unique case (1'b1)
      (size_i == MEM_SIZE_B): begin
        sel_o   = 4'b1000 >> addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        // byte 0 lives in bits 31:24
        sh      = {~addr_lo_i, 3'b000};
        rdata_o = {24'h0, rdata_i[sh +: 8]};
      end
      (size_i == MEM_SIZE_H): begin
        sel_o   = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'h0, addr_lo_i[1] ? rdata_i[15:0]
                                       : rdata_i[31:16]};
      end
      default: begin
        sel_o   = 4'hF;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/cpu_memstage.sv
// Memory pipeline stage: passes ALU results through or runs
// one Wishbone load/store, stalling execute while busy.
module cpu_memstage
  import cpu_memstage_pkg::*;
#(
  parameter int BUS_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 valid_i,
  input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
  input  logic [1:0]           mem_op_i,
  input  logic [1:0]           mem_size_i,
  input  logic [31:0]          memory_address_i,
  input  logic [31:0]          store_data_i,
  input  logic [31:0]          result_i,
  input  logic [31:0]          PC_i,
  output logic                 stall_o,
  output logic                 valid_o,
  output logic [PCB_WIDTH-1:0] pipeline_control_bits_o,
  output logic [31:0]          memory_address_o,
  output logic [31:0]          mem_result_o,
  output logic [31:0]          PC_o,
  output logic                 align_err_o,
  output logic                 bus_err_o,
  cpu_memstage_if.master       dwb
);

  state_e state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic flushed_q, flushed_d;
  logic [31:0] adr_q, adr_d, dat_q, dat_d;
  logic [3:0] sel_q, sel_d;
  logic we_q, we_d;
  logic [1:0] size_q, size_d, alo_q, alo_d;
  logic valid_q, valid_d, aerr_q, aerr_d;
  logic berr_q, berr_d;
  logic [PCB_WIDTH-1:0] pcb_q, pcb_d;
  logic [31:0] maddr_q, maddr_d, res_q, res_d;
  logic [31:0] pc_q, pc_d;

  logic busy, is_mem, ok, to_hit, kill, stall;
  logic [1:0] l_size, l_lo;
  logic [3:0] l_sel;
  logic [31:0] l_wdat, l_rdat;

  assign busy   = (state_q == S_BUS);
  assign l_size = busy ? size_q : mem_size_i;
  assign l_lo   = busy ? alo_q : memory_address_i[1:0];

  cpu_memlane u_lane (
    .size_i    (l_size),
    .addr_lo_i (l_lo),
    .wdata_i   (store_data_i),
    .rdata_i   (dwb.dat_r),
    .sel_o     (l_sel),
    .wdata_o   (l_wdat),
    .rdata_o   (l_rdat)
  );

  assign is_mem = (mem_op_i == MEM_OP_LOAD) ||
                  (mem_op_i == MEM_OP_STORE);
  assign ok     = is_aligned(mem_size_i,
                             memory_address_i[1:0]);
  assign to_hit = (cnt_q == TO_W'(BUS_TIMEOUT));
  assign kill   = flushed_q | flush_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flushed_d = flushed_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    size_d    = size_q;
    alo_d     = alo_q;
    pcb_d     = pcb_q;
    maddr_d   = maddr_q;
    res_d     = res_q;
    pc_d      = pc_q;
    valid_d   = 1'b0;
    aerr_d    = 1'b0;
    berr_d    = 1'b0;
    stall     = 1'b0;
    if (state_q == S_IDLE) begin
      if (valid_i && !flush_i) begin
        pcb_d   = pipeline_control_bits_i;
        maddr_d = memory_address_i;
        pc_d    = PC_i;
        if (!is_mem) begin
          valid_d = 1'b1;
          res_d   = result_i;
        end else if (!ok) begin
          aerr_d = 1'b1;
        end else begin
          res_d     = store_data_i;
          adr_d     = {memory_address_i[31:2], 2'b00};
          dat_d     = l_wdat;
          sel_d     = l_sel;
          we_d      = (mem_op_i == MEM_OP_STORE);
          size_d    = mem_size_i;
          alo_d     = memory_address_i[1:0];
          cnt_d     = TO_W'(1);
          flushed_d = 1'b0;
          state_d   = S_BUS;
          stall     = 1'b1;
        end
      end
    end else begin
      flushed_d = kill;
      // an error on the same edge as ack takes priority
      if (dwb.err || to_hit) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        berr_d  = ~kill;
      end else if (dwb.ack) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        valid_d = ~kill;
        if (!we_q) res_d = l_rdat;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
        stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      alo_q     <= '0;
      valid_q   <= 1'b0;
      aerr_q    <= 1'b0;
      berr_q    <= 1'b0;
      pcb_q     <= '0;
      maddr_q   <= '0;
      res_q     <= '0;
      pc_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      size_q    <= size_d;
      alo_q     <= alo_d;
      valid_q   <= valid_d;
      aerr_q    <= aerr_d;
      berr_q    <= berr_d;
      pcb_q     <= pcb_d;
      maddr_q   <= maddr_d;
      res_q     <= res_d;
      pc_q      <= pc_d;
    end
  end

  assign stall_o                 = stall;
  assign valid_o                 = valid_q;
  assign align_err_o             = aerr_q;
  assign bus_err_o               = berr_q;
  assign pipeline_control_bits_o = pcb_q;
  assign memory_address_o        = maddr_q;
  assign mem_result_o            = res_q;
  assign PC_o                    = pc_q;

  assign dwb.adr   = adr_q;
  assign dwb.dat_w = dat_q;
  assign dwb.sel   = busy ? sel_q : 4'h0;
  assign dwb.we    = busy & we_q;
  assign dwb.cyc   = busy;
  assign dwb.stb   = busy;

endmodule
